fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-domain controller for the async FIFO. It is the parametrised successor of the existing write-pointer block and adds the following:
- parametrised depth;
- an internal multi-stage synchroniser for the read pointer;
- a registered gray-coded write pointer for the read domain;
- a registered full flag;
- a fill-level count and a programmable almost-full flag;
- a sticky overflow flag.

It sits between the write-side client and the dual-port FIFO memory, and exports the gray pointer to the read-side controller.

Parameters:
ADDR_W, 3, memory address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits; legal range is ADDR_W >= 2.
SYNC_STAGES, 2, number of flops in the read-pointer synchroniser; legal range is SYNC_STAGES >= 2.

Ports:
w_clk  in  1  write-domain clock; the block's only clock.
w_rstn  in  1  asynchronous active-low reset.
w_inc  in  1  write request from the client.
rd_gptr_async  in  ADDR_W+1  gray read pointer from the read domain; asynchronous to w_clk.
af_thresh  in  ADDR_W+1  almost-full threshold in words; quasi-static.
ovf_clr  in  1  clears the overflow flag.
w_en  out  1  memory write strobe.
w_addr  out  ADDR_W  memory write address (binary).
w_gptr  out  ADDR_W+1  registered gray write pointer, exported to the read domain.
full  out  1  FIFO full flag, registered.
almost_full  out  1  fill level >= af_thresh, registered.
w_count  out  ADDR_W+1  fill level as seen from the write domain, registered.
overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
Reset:
- All of wbin (internal binary pointer), w_gptr, the synchroniser flops, full, almost_full, w_count and overflow go to 0 asynchronously while w_rstn = 0.
- Release is synchronous to w_clk; no deassertion logic is needed inside the block.
- Reset asserted mid-operation discards all state immediately. The read domain must be reset in the same event.

Synchroniser:
- rd_gptr_async passes through SYNC_STAGES flops to give rq.
- rq is converted gray-to-binary to give rbin (XOR prefix from the MSB).
- There is no logic on rd_gptr_async before the first flop.

Write acceptance:
- w_en = w_inc & ~full (combinational from the registered full).
- w_addr = wbin[ADDR_W-1:0].
- Memory writes data at w_addr on the same edge that wbin advances.

Next-state values (computed combinationally, registered at the edge):
- wbin_n = wbin + w_en, modulo 2**(ADDR_W+1), so it wraps naturally.
- wgray_n = (wbin_n >> 1) ^ wbin_n.

Registers updated each edge:
- wbin <= wbin_n.
- w_gptr <= wgray_n. w_gptr changes at most one bit per edge.
- full <= (wgray_n == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]}).
- w_count <= wbin_n - rbin, modulo 2**(ADDR_W+1); range 0..2**ADDR_W.
- almost_full <= ((wbin_n - rbin) >= af_thresh), unsigned compare.
  - af_thresh = 0 gives almost_full constantly 1 after the first edge.
  - af_thresh > 2**ADDR_W gives almost_full never asserted.

Latency and timing:
- full asserts on the same edge that accepts the last free slot. A write in the next cycle is therefore blocked with zero slack.
- full deasserts SYNC_STAGES+1 edges after rd_gptr_async changes, i.e. it is released pessimistically.
- w_count and almost_full lag the read side by the same amount and are exact with respect to writes.

Overflow:
- overflow <= 1 on any edge where w_inc & full.
- It is cleared by ovf_clr = 1.
- If the set condition and ovf_clr occur on the same edge, set wins.
- An overflowing request has no other effect: the pointer holds and w_en = 0.

Simultaneous events:
- A write accepted on the same edge that rq advances produces full/count computed from the new wbin_n and the current rq.

Test Plan:
All scenarios use ADDR_W=3 and SYNC_STAGES=2.
1. Reset: drive random inputs with w_rstn=0 -> w_gptr=0, w_addr=0, full=0, almost_full=0 (af_thresh=6), w_count=0, overflow=0. Pulse reset mid-burst -> all outputs return to 0 asynchronously, before the next edge.
2. Fill: hold rd_gptr_async=0 and assert w_inc for 8 cycles -> w_addr steps 0..7 with w_en=1. After the 8th edge: full=1, w_count=8, w_gptr=4'b1100. almost_full rises on the edge where w_count becomes 6.
3. Overflow: with full=1, assert w_inc 1 cycle -> w_en=0, w_addr stays 0, overflow=1 on the next edge. Pulse ovf_clr -> overflow=0. Assert ovf_clr and an overflowing w_inc together -> overflow stays 1.
4. Release: from full, set rd_gptr_async=4'b0001 (rbin=1) -> full stays 1 for 2 edges and drops on the 3rd edge, where w_count=7. The next w_inc writes w_addr=0.
5. Wrap: the read side tracks the writer one word behind. Perform 16 accepted writes -> w_gptr sequence follows gray 1..15 then 0; no spurious full; w_count never exceeds 1. A checker confirms w_gptr flips exactly one bit per change.
6. Concurrent edge: a write is accepted on the same edge that rq advances by 1 at count 7 -> w_count stays 7 and full stays 0.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO write controller: client handshake,
// memory write port, cross-domain pointers and status flags.
interface fifo_wr_ctrl_if #(
    parameter int unsigned ADDR_W = 3
);
    logic              w_inc;
    logic [ADDR_W:0]   rd_gptr_async;
    logic [ADDR_W:0]   af_thresh;
    logic              ovf_clr;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W:0]   w_gptr;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   w_count;
    logic              overflow;

    // Client / environment side
    modport master (
        output w_inc, rd_gptr_async, af_thresh, ovf_clr,
        input  w_en, w_addr, w_gptr, full, almost_full, w_count, overflow
    );

    // Controller side
    modport slave (
        input  w_inc, rd_gptr_async, af_thresh, ovf_clr,
        output w_en, w_addr, w_gptr, full, almost_full, w_count, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: binary/gray write pointer,
// read-pointer synchroniser, full / almost-full / fill-level and sticky overflow.
module fifo_wr_ctrl #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           w_clk,
    input  logic           w_rstn,
    fifo_wr_ctrl_if.slave  bus
);
    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] sync_q [SYNC_STAGES];
    logic [PTR_W-1:0] rq;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_n;
    logic [PTR_W-1:0] wgray_n;
    logic [PTR_W-1:0] count_n;
    logic [PTR_W-1:0] full_match;
    logic [PTR_W-1:0] w_gptr_q;
    logic [PTR_W-1:0] w_count_q;
    logic             full_q;
    logic             almost_full_q;
    logic             overflow_q;
    logic             w_en_c;

    // Read-pointer synchroniser chain; first flop samples the async input directly
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.rd_gptr_async;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq = sync_q[SYNC_STAGES-1];

    // Gray-to-binary of the synchronised read pointer (XOR prefix from the MSB)
    always_comb begin
        rbin = '0;
        for (int unsigned i = 0; i < PTR_W; i++) begin
            rbin[i] = ^(rq >> i);
        end
    end

    // Next pointer, next gray, next fill level; full when the gray pointers differ in the top two bits only
    always_comb begin
        w_en_c     = bus.w_inc & ~full_q;
        wbin_n     = wbin + PTR_W'(w_en_c);
        wgray_n    = (wbin_n >> 1) ^ wbin_n;
        count_n    = wbin_n - rbin;
        full_match = {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]};
    end

    // Pointer and status registers
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            wbin          <= '0;
            w_gptr_q      <= '0;
            full_q        <= 1'b0;
            w_count_q     <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wbin          <= wbin_n;
            w_gptr_q      <= wgray_n;
            full_q        <= (wgray_n == full_match);
            w_count_q     <= count_n;
            almost_full_q <= (count_n >= bus.af_thresh);
        end
    end

    // Sticky overflow; a new overflow wins over a simultaneous clear
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            overflow_q <= 1'b0;
        end else if (bus.w_inc & full_q) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.w_en        = w_en_c;
    assign bus.w_addr      = wbin[ADDR_W-1:0];
    assign bus.w_gptr      = w_gptr_q;
    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.w_count     = w_count_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a pointer-arithmetic reference model.
module tb_fifo_wr_ctrl;
    localparam int unsigned AW = 3;
    localparam int unsigned PW = AW + 1;
    localparam int MOD   = 16;
    localparam int DEPTH = 8;

    logic w_clk = 1'b0;
    logic w_rstn;

    fifo_wr_ctrl_if #(.ADDR_W(AW)) bus ();

    fifo_wr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .w_clk  (w_clk),
        .w_rstn (w_rstn),
        .bus    (bus.slave)
    );

    always #5 w_clk = ~w_clk;

    int total  = 0;
    int passed = 0;

    // Reference model: writes/reads as plain counters modulo 2*DEPTH
    int m_wptr, m_full, m_af, m_cnt, m_ovf;
    int m_s0, m_s1;
    int rd_bin;
    int prev_gptr;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_wptr = 0; m_full = 0; m_af = 0; m_cnt = 0; m_ovf = 0;
        m_s0 = 0; m_s1 = 0; prev_gptr = 0;
    endtask

    task automatic model_edge();
        int acc;
        int nw;
        int c;
        acc = (bus.w_inc && m_full == 0) ? 1 : 0;
        if (bus.w_inc && m_full != 0) m_ovf = 1;
        else if (bus.ovf_clr) m_ovf = 0;
        nw     = (m_wptr + acc) % MOD;
        c      = (nw - m_s1 + MOD) % MOD;
        m_cnt  = c;
        m_full = (c == DEPTH) ? 1 : 0;
        m_af   = (c >= int'(bus.af_thresh)) ? 1 : 0;
        m_wptr = nw;
        m_s1   = m_s0;
        m_s0   = rd_bin;
    endtask

    task automatic drive_rd();
        bus.rd_gptr_async = PW'(gray(rd_bin));
    endtask

    task automatic check_all(input string tag);
        check({tag, ".w_addr"},   32'(bus.w_addr),      32'(m_wptr % DEPTH));
        check({tag, ".w_gptr"},   32'(bus.w_gptr),      32'(gray(m_wptr)));
        check({tag, ".full"},     32'(bus.full),        32'(m_full));
        check({tag, ".af"},       32'(bus.almost_full), 32'(m_af));
        check({tag, ".w_count"},  32'(bus.w_count),     32'(m_cnt));
        check({tag, ".overflow"}, 32'(bus.overflow),    32'(m_ovf));
        check({tag, ".w_en"},     32'(bus.w_en),        32'((bus.w_inc && m_full == 0) ? 1 : 0));
        check({tag, ".gray_step"}, 32'($countones(bus.w_gptr ^ PW'(prev_gptr)) <= 1), 32'(1));
        prev_gptr = int'(bus.w_gptr);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later
    task automatic cycle(input string tag);
        @(posedge w_clk);
        if (w_rstn) model_edge();
        else model_reset();
        #1;
        check_all(tag);
    endtask

    initial begin
        w_rstn = 1'b0;
        bus.w_inc = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.af_thresh = PW'(6);
        rd_bin = 0;
        drive_rd();
        model_reset();

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            bus.w_inc   = 1'($urandom);
            bus.ovf_clr = 1'($urandom);
            rd_bin      = int'($urandom_range(0, 15));
            drive_rd();
            cycle("reset");
        end
        bus.w_inc = 1'b0;
        bus.ovf_clr = 1'b0;
        rd_bin = 0;
        drive_rd();
        w_rstn = 1'b1;
        cycle("release");

        // Fill eight slots with the reader parked at zero
        bus.w_inc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check("fill.addr_pre", 32'(bus.w_addr), 32'(k - 1));
            check("fill.w_en_pre", 32'(bus.w_en), 32'(1));
            cycle("fill");
            check("fill.af_rise", 32'(bus.almost_full), 32'((k >= 6) ? 1 : 0));
        end
        check("fill.full", 32'(bus.full), 32'(1));
        check("fill.count", 32'(bus.w_count), 32'(8));
        check("fill.gptr", 32'(bus.w_gptr), 32'(12));

        // Overflow set, clear, and set-wins-over-clear
        #1;
        check("ovf.w_en_pre", 32'(bus.w_en), 32'(0));
        cycle("ovf_set");
        check("ovf.flag", 32'(bus.overflow), 32'(1));
        check("ovf.addr_hold", 32'(bus.w_addr), 32'(0));
        bus.w_inc = 1'b0;
        bus.ovf_clr = 1'b1;
        cycle("ovf_clr");
        check("ovf.cleared", 32'(bus.overflow), 32'(0));
        bus.w_inc = 1'b1;
        cycle("ovf_both");
        check("ovf.set_wins", 32'(bus.overflow), 32'(1));
        bus.w_inc = 1'b0;
        bus.ovf_clr = 1'b0;

        // Release: one read, full drops on the third edge
        rd_bin = 1;
        drive_rd();
        cycle("rel1");
        check("rel.full_e1", 32'(bus.full), 32'(1));
        cycle("rel2");
        check("rel.full_e2", 32'(bus.full), 32'(1));
        cycle("rel3");
        check("rel.full_e3", 32'(bus.full), 32'(0));
        check("rel.count_e3", 32'(bus.w_count), 32'(7));
        bus.w_inc = 1'b1;
        #1;
        check("rel.next_addr", 32'(bus.w_addr), 32'(0));
        check("rel.next_w_en", 32'(bus.w_en), 32'(1));
        cycle("rel_wr");
        bus.w_inc = 1'b0;

        // Concurrent: write lands on the edge that first uses the advanced rq
        rd_bin = 2;
        drive_rd();
        for (int k = 0; k < 3; k++) cycle("conc_pre");
        check("conc.count_pre", 32'(bus.w_count), 32'(7));
        rd_bin = 3;
        drive_rd();
        cycle("conc_s1");
        cycle("conc_s2");
        bus.w_inc = 1'b1;
        cycle("conc_wr");
        check("conc.count", 32'(bus.w_count), 32'(7));
        check("conc.full", 32'(bus.full), 32'(0));

        // Asynchronous reset in the middle of a burst
        cycle("burst");
        #3;
        w_rstn = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst.gptr", 32'(bus.w_gptr), 32'(0));
        bus.w_inc = 1'b0;
        rd_bin = 0;
        drive_rd();
        cycle("rst_hold");
        w_rstn = 1'b1;

        // Wrap: reader follows one word behind, sixteen writes
        for (int k = 1; k <= 16; k++) begin
            bus.w_inc = 1'b1;
            cycle("wrap_wr");
            check("wrap.gptr", 32'(bus.w_gptr), 32'(gray(k % MOD)));
            check("wrap.count_le1", 32'(bus.w_count <= PW'(1)), 32'(1));
            bus.w_inc = 1'b0;
            rd_bin = m_wptr;
            drive_rd();
            for (int j = 0; j < 3; j++) begin
                cycle("wrap_idle");
                check("wrap.idle_le1", 32'(bus.w_count <= PW'(1)), 32'(1));
            end
        end

        // Randomized traffic with threshold sweep including 0 and > depth
        for (int c = 0; c < 400; c++) begin
            if (c % 100 == 0) begin
                case (c / 100)
                    0: bus.af_thresh = PW'(0);
                    1: bus.af_thresh = PW'(9);
                    2: bus.af_thresh = PW'(8);
                    default: bus.af_thresh = PW'($urandom_range(1, 7));
                endcase
            end
            bus.w_inc   = ($urandom_range(0, 9) < 6);
            bus.ovf_clr = ($urandom_range(0, 7) == 0);
            if (((m_wptr - rd_bin + MOD) % MOD) > 0 && $urandom_range(0, 2) == 0) begin
                rd_bin = (rd_bin + 1) % MOD;
            end
            drive_rd();
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
